// File: rtl/dig_spi_pkg.sv
// Shared constants and FSM state encoding for the SPI responder.
// Frame: bit15 R/W (1 = read), bits14:8 address, bits7:0 data.
package dig_spi_pkg;
  localparam int FRAME_BITS = 16;
  localparam int ADDR_W     = 7;
  localparam int DATA_W     = 8;
  localparam int CNT_W      = 5;

  localparam logic [CNT_W-1:0] CNT_HDR_LAST = CNT_W'(ADDR_W);
  localparam logic [CNT_W-1:0] CNT_FULL     = CNT_W'(FRAME_BITS);
  localparam logic [CNT_W-1:0] CNT_LAST     = CNT_FULL - 1'b1;
  localparam logic [CNT_W-1:0] CNT_SAT      = CNT_FULL + 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    WDATA,
    RDATA,
    DRAIN
  } state_e;
endpackage

// File: rtl/sync_edge.sv
// Synchronizer chain plus rise/fall detector for one async input.
// Ports: clk, rst, d (pin) -> q (synced level), rise, fall.
module sync_edge #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);
  logic [STAGES-1:0] sync_q, sync_d;
  logic              dly_q, dly_d;

  always_comb begin
    sync_d[0] = d;
    for (int i = 1; i < STAGES; i++) begin
      sync_d[i] = sync_q[i-1];
    end
    dly_d = sync_q[STAGES-1];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= {STAGES{RST_VAL}};
      dly_q  <= RST_VAL;
    end else begin
      sync_q <= sync_d;
      dly_q  <= dly_d;
    end
  end

  assign q    = sync_q[STAGES-1];
  assign rise = q & ~dly_q;
  assign fall = ~q & dly_q;
endmodule

// File: rtl/dig_spi_responder.sv
// 16-bit SPI slave bridging a serial master to a register file.
// Ports: sen_n/sclk/sdata in, sdout/sdout_oe out, reg_* bus, frame_err.
module dig_spi_responder
  import dig_spi_pkg::*;
#(
  parameter logic SCLK_IDLE   = 1'b1,
  parameter int   SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sen_n,
  input  logic              sclk,
  input  logic              sdata,
  output logic              sdout,
  output logic              sdout_oe,
  output logic              reg_wr_en,
  output logic [ADDR_W-1:0] reg_wr_addr,
  output logic [DATA_W-1:0] reg_wr_data,
  output logic [ADDR_W-1:0] reg_rd_addr,
  input  logic [DATA_W-1:0] reg_rd_data,
  output logic              frame_err
);
  logic sen_s, sen_rise, sen_fall;
  logic sclk_rise, sclk_fall, sclk_lvl_unused;
  logic sdata_s, sdata_rise_unused, sdata_fall_unused;

  sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sen (
    .clk  (clk),
    .rst  (rst),
    .d    (sen_n),
    .q    (sen_s),
    .rise (sen_rise),
    .fall (sen_fall)
  );

  sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(SCLK_IDLE)) u_sclk (
    .clk  (clk),
    .rst  (rst),
    .d    (sclk),
    .q    (sclk_lvl_unused),
    .rise (sclk_rise),
    .fall (sclk_fall)
  );

  // Same depth as sclk so each sample lines up with its edge.
  sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sdata (
    .clk  (clk),
    .rst  (rst),
    .d    (sdata),
    .q    (sdata_s),
    .rise (sdata_rise_unused),
    .fall (sdata_fall_unused)
  );

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [6:0]        sh_q, sh_d;
  logic              rw_q, rw_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic [1:0]        ld_q, ld_d;
  logic [DATA_W-1:0] osh_q, osh_d;
  logic              sdout_q, sdout_d;
  logic              oe_q, oe_d;
  logic              ferr_q, ferr_d;

  logic rise_ok, fall_ok, rd_phase;

  assign rise_ok  = sclk_rise & ~sen_s;
  assign fall_ok  = sclk_fall & ~sen_s;
  assign rd_phase = rw_q & ((state_q == RDATA) | (state_q == DRAIN));

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    sh_d      = sh_q;
    rw_d      = rw_q;
    addr_d    = addr_q;
    data_d    = data_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    rd_addr_d = rd_addr_q;
    ld_d      = {ld_q[0], 1'b0};
    osh_d     = osh_q;
    sdout_d   = sdout_q;
    oe_d      = oe_q;
    ferr_d    = 1'b0;

    // Read data arrives one clk after the address is registered.
    if (ld_q[1]) osh_d = reg_rd_data;

    // SEN rise wins over any sclk edge seen in the same clk.
    if (state_q != IDLE && sen_rise) begin
      state_d = IDLE;
      oe_d    = 1'b0;
      sdout_d = 1'b0;
      ld_d    = 2'b00;
      if (state_q == DRAIN && cnt_q == CNT_FULL) begin
        if (!rw_q) begin
          wr_en_d   = 1'b1;
          wr_addr_d = addr_q;
          wr_data_d = data_q;
        end
      end else begin
        ferr_d = 1'b1;
      end
    end else begin
      unique case (state_q)
        IDLE: begin
          if (sen_fall) begin
            state_d = ADDR;
            cnt_d   = '0;
          end
        end
        ADDR: begin
          if (rise_ok) begin
            cnt_d = cnt_q + 1'b1;
            sh_d  = {sh_q[5:0], sdata_s};
            if (cnt_q == CNT_HDR_LAST) begin
              rw_d   = sh_q[6];
              addr_d = {sh_q[5:0], sdata_s};
              if (sh_q[6]) begin
                state_d   = RDATA;
                rd_addr_d = {sh_q[5:0], sdata_s};
                ld_d      = 2'b01;
              end else begin
                state_d = WDATA;
              end
            end
          end
        end
        WDATA: begin
          if (rise_ok) begin
            cnt_d = cnt_q + 1'b1;
            sh_d  = {sh_q[5:0], sdata_s};
            if (cnt_q == CNT_LAST) begin
              data_d  = {sh_q, sdata_s};
              state_d = DRAIN;
            end
          end
        end
        RDATA: begin
          if (rise_ok) begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CNT_LAST) state_d = DRAIN;
          end
        end
        DRAIN: begin
          if (rise_ok && cnt_q != CNT_SAT) cnt_d = cnt_q + 1'b1;
        end
        default: state_d = IDLE;
      endcase

      if (fall_ok && rd_phase) begin
        oe_d    = 1'b1;
        sdout_d = osh_q[DATA_W-1];
        osh_d   = {osh_q[DATA_W-2:0], 1'b0};
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      sh_q      <= '0;
      rw_q      <= 1'b0;
      addr_q    <= '0;
      data_q    <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      rd_addr_q <= '0;
      ld_q      <= '0;
      osh_q     <= '0;
      sdout_q   <= 1'b0;
      oe_q      <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      sh_q      <= sh_d;
      rw_q      <= rw_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      rd_addr_q <= rd_addr_d;
      ld_q      <= ld_d;
      osh_q     <= osh_d;
      sdout_q   <= sdout_d;
      oe_q      <= oe_d;
      ferr_q    <= ferr_d;
    end
  end

  assign sdout       = sdout_q & oe_q;
  assign sdout_oe    = oe_q;
  assign reg_wr_en   = wr_en_q;
  assign reg_wr_addr = wr_addr_q;
  assign reg_wr_data = wr_data_q;
  assign reg_rd_addr = rd_addr_q;
  assign frame_err   = ferr_q;
endmodule
